// File: rtl/dmem_pkg.sv
// Shared types and address decode for the data-memory responder.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef struct packed {
        logic        err;
        logic [31:0] idx;
    } addr_chk_t;

    // Index is the full word offset; the caller keeps only the low bits it needs.
    function automatic addr_chk_t addr_check(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] depth
    );
        addr_chk_t   r;
        logic [31:0] off;
        off   = addr - base;
        r.idx = {2'b00, off[31:2]};
        r.err = (addr[1:0] != 2'b00) || (addr < base) || (r.idx >= depth);
        return r;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between MEM stage and responder.
interface dmem_responder_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables and registered read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [WORD_W-1:0]              wdata,
    input  logic [BE_W-1:0]                be,
    output logic [WORD_W-1:0]              rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        if (en && !we) begin
            rdata_q <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: one outstanding load/store at a time.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              we_q, we_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [WORD_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              acc_en;
    logic              acc_we;
    logic [WORD_W-1:0] acc_addr;
    logic [WORD_W-1:0] acc_wdata;
    logic [BE_W-1:0]   acc_be;
    addr_chk_t         acc_chk;
    addr_chk_t         rsp_chk;
    logic [WORD_W-1:0] ram_rdata;

    // With zero wait states the access happens on the accept edge itself.
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_be    = be_q;
        if (state_q == IDLE) begin
            acc_we    = bus.req_we;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
            acc_be    = bus.req_be;
        end
    end

    assign acc_chk = addr_check(acc_addr, ADDR_BASE, 32'(DEPTH_WORDS));
    assign rsp_chk = addr_check(addr_q, ADDR_BASE, 32'(DEPTH_WORDS));

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .en   (acc_en && !acc_chk.err),
        .we   (acc_we),
        .idx  (acc_chk.idx[IDX_W-1:0]),
        .wdata(acc_wdata),
        .be   (acc_be),
        .rdata(ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        acc_en      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d        = bus.req_we;
                    addr_d      = bus.req_addr;
                    wdata_d     = bus.req_wdata;
                    be_d        = bus.req_be;
                    req_ready_d = 1'b0;
                    if (WAIT_CYCLES == 0) begin
                        acc_en  = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    acc_en  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // First RESP cycle registers the RAM read into the response.
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = rsp_chk.err;
                    rsp_rdata_d = (we_q || rsp_chk.err) ? '0 : ram_rdata;
                end else if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the processor's data-memory port. Accepts one load/store request at a time from the MEM stage over a valid/ready request channel.
- Services each request against an internal word-addressed array after a configurable number of wait states. Returns read data or write completion over a valid/ready response channel.
- Sits between the processor's MEM-stage initiator and on-chip data storage. Replaces the zero-latency data memory so pipeline stall logic can be exercised.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array (power of two, ≥ 4).
- WAIT_CYCLES, 2, wait states between request acceptance and response (0..15).
- ADDR_BASE, 32'h0000_0000, byte address of word 0 (word-aligned).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  byte enables for stores; bit i maps to wdata[8i+7:8i].
- rsp_valid  output  1  response available.
- rsp_ready  input  1  initiator accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  request was misaligned or out of range.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0; wait counter=0.
  - Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Handshake (req_valid & req_ready) latches we, addr, wdata, be.
  - Goes to WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1); otherwise goes directly to RESP next cycle.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - On the counter=0 cycle, performs the access and goes to RESP.
- Access point (last WAIT cycle, or the accept cycle when WAIT_CYCLES=0):
  - Store writes enabled bytes only; be=4'b0000 is a legal no-op write.
  - Load registers array[index] into rsp_rdata.
  - Response is registered: rsp_valid rises the cycle after the access point.
- Latency: accept edge to rsp_valid high = WAIT_CYCLES+1 cycles.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready.
  - On that handshake, returns to IDLE and clears rsp_valid, rsp_rdata and rsp_err in the same edge.
  - req_ready stays 0 in RESP. No new request is accepted in the response-handshake cycle; next accept is earliest one cycle later.
- Address rules:
  - index = (req_addr - ADDR_BASE) >> 2, width clog2(DEPTH_WORDS).
  - Error if req_addr[1:0] != 0, req_addr < ADDR_BASE, or index ≥ DEPTH_WORDS.
  - On error: no array write, rsp_rdata=0, rsp_err=1; wait states still apply.
- Load data: no sign/byte extraction; the full word is returned and byte/half selection is the initiator's job.
- Backpressure: rsp_ready low holds RESP indefinitely with outputs stable; req_valid is ignored meanwhile.
- Reset mid-operation:
  - Reset asserted in WAIT before the access point: request is abandoned, no write occurs.
  - Reset asserted in RESP: the write already happened; the response is dropped.
- Request inputs are sampled only on the accept edge; later changes have no effect.

Decomposition:
- Shared package dmem_pkg:
  - state enum (IDLE, WAIT, RESP);
  - WORD_W=32, BE_W=4;
  - function computing the index/error flag from addr, ADDR_BASE, DEPTH_WORDS.
- Sub-module dmem_array:
  - synchronous single-port RAM with 4 byte-write enables, registered read, DEPTH_WORDS parameter;
  - instantiated once, driven by the FSM at the access point.

Test Plan:
- Store then load, WAIT_CYCLES=2: store 0x0000_0010 ← 0xDEADBEEF, be=4'hF, rsp_ready=1 → rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0; load 0x10 → rsp_rdata=0xDEADBEEF 3 cycles after accept.
- Partial store: word 0x10 holds 0xDEADBEEF; store 0x10 data 0x1122_3344, be=4'b0101 → subsequent load returns 0xDE22BE44.
- Errors:
  - load 0x0000_0012 → rsp_err=1, rsp_rdata=0;
  - store to 0x0000_0400 with DEPTH_WORDS=256 → rsp_err=1 and word 0 is unchanged on readback.
- Backpressure: load with rsp_ready=0 for 5 cycles → rsp_valid stays 1 with rdata stable, req_ready=0 throughout, a concurrent req_valid is not accepted; raise rsp_ready → IDLE next cycle, req_ready=1.
- WAIT_CYCLES=0 back-to-back: accept cycle N → rsp_valid at N+1; with rsp_ready=1, second request accepted at N+3.
- Reset mid-wait: store 0x20 ← 0xCAFEF00D, assert reset one cycle after accept (WAIT_CYCLES=3) → outputs at reset values immediately; after release, load 0x20 returns the previous value, not 0xCAFEF00D.
